sysbus_mem_responder: RTL and testbench

SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

---
 rtl/sysbus_mem_responder_pkg.sv | 37 +++
 rtl/sysbus_mem_responder_if.sv | 28 ++
 rtl/sysbus_mem_array.sv | 33 +++
 rtl/sysbus_mem_responder.sv | 158 +++++++++++++++
 tb/tb_sysbus_mem_responder.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sysbus_mem_responder_pkg.sv
// Shared system-bus definitions for the memory responder.
//   - request tag layout (wr, type, priv) and its field encodings
//   - beat count of a cache-line burst and the line buffer type
//   - small decode helpers used by the responder FSM
package sysbus_mem_responder_pkg;

  localparam int DATA_W     = 64;
  localparam int TAG_W      = 13;
  localparam int BEAT_COUNT = 8;

  // Direction bit of the tag.
  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } sysbus_wr_e;

  localparam logic [3:0] TYPE_MEMORY = 4'b0001;

  // reqtag[12] = wr, reqtag[11:8] = type, reqtag[7:0] = priv
  typedef struct packed {
    sysbus_wr_e wr;
    logic [3:0] typ;
    logic [7:0] priv;
  } sysbus_tag_t;

  // One 64-byte line, beat 0 in element 0.
  typedef logic [BEAT_COUNT-1:0][DATA_W-1:0] sysbus_line_t;

  function automatic logic is_mem_write(input sysbus_tag_t t);
    return (t.wr == WRITE) && (t.typ == TYPE_MEMORY);
  endfunction

  function automatic logic is_mem_read(input sysbus_tag_t t);
    return (t.wr == READ) && (t.typ == TYPE_MEMORY);
  endfunction

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Request/response bundle between a bus initiator and the memory responder.
//   reqcyc/req/reqtag : initiator -> responder (request and write beats)
//   reqack            : responder -> initiator, one-cycle accept pulse
//   respcyc/resp/resptag : responder -> initiator, read burst beats
//   respack           : initiator -> responder, accepts current beat
interface sysbus_mem_responder_if;
  import sysbus_mem_responder_pkg::*;

  logic              reqcyc;
  logic [DATA_W-1:0] req;
  logic [TAG_W-1:0]  reqtag;
  logic              reqack;
  logic              respcyc;
  logic [DATA_W-1:0] resp;
  logic [TAG_W-1:0]  resptag;
  logic              respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );

endinterface

// File: rtl/sysbus_mem_array.sv
// Backing store for the memory responder.
//   clk         : write clock
//   rd_idx      : word index, read combinationally onto rd_data
//   we          : write a whole line on the next rising edge
//   wr_line_idx : line number (word index without the beat bits)
//   wr_line     : eight words, beat 0 lands at the lowest index
// Contents are deliberately left out of reset so data survives it.
module sysbus_mem_array
  import sysbus_mem_responder_pkg::*;
#(
  parameter int WORDS = 4096
) (
  input  logic                       clk,
  input  logic [$clog2(WORDS)-1:0]   rd_idx,
  output logic [DATA_W-1:0]          rd_data,
  input  logic                       we,
  input  logic [$clog2(WORDS)-4:0]   wr_line_idx,
  input  sysbus_line_t               wr_line
);

  logic [DATA_W-1:0] mem [WORDS];

  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BEAT_COUNT; i++) begin
        mem[{wr_line_idx, 3'(i)}] <= wr_line[i];
      end
    end
  end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Cache-line memory responder on the system bus.
//   clk, reset : single clock, asynchronous active-high reset
//   bus        : slave side of the request/response bundle
// A request is accepted from IDLE and acknowledged for one cycle. Memory
// writes then collect eight data beats and commit the line in one cycle;
// memory reads wait LATENCY+1 cycles and stream eight beats under respack
// backpressure. Any other tag type is acknowledged and dropped.
module sysbus_mem_responder
  import sysbus_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  sysbus_mem_responder_if.slave  bus
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int LINE_W = IDX_W - 3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACK    = 3'd1;
  localparam logic [2:0] S_WDATA  = 3'd2;
  localparam logic [2:0] S_RDELAY = 3'd3;
  localparam logic [2:0] S_RBURST = 3'd4;

  localparam logic [3:0] LAT_LAST  = 4'(LATENCY);
  localparam logic [3:0] BEAT_DONE = 4'(BEAT_COUNT);
  localparam logic [3:0] BEAT_LAST = 4'(BEAT_COUNT - 1);

  logic [2:0]        state_q, state_d;
  logic [LINE_W-1:0] line_q,  line_d;
  sysbus_tag_t       tag_q,   tag_d;
  logic [3:0]        beat_q,  beat_d;
  logic [3:0]        lat_q,   lat_d;
  sysbus_line_t      wbuf_q,  wbuf_d;

  logic              mem_we;
  logic [DATA_W-1:0] rd_data;
  sysbus_tag_t       req_tag;

  assign req_tag = sysbus_tag_t'(bus.reqtag);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    line_d  = line_q;
    tag_d   = tag_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    wbuf_d  = wbuf_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.reqcyc) begin
          state_d = S_ACK;
          // Only the line bits that reach the array are kept; addr[5:0]
          // and bits above the array depth never affect the index.
          line_d  = bus.req[IDX_W+2:6];
          tag_d   = req_tag;
          beat_d  = '0;
          lat_d   = '0;
        end
      end

      S_ACK: begin
        if (is_mem_write(tag_q)) begin
          state_d = S_WDATA;
        end else if (is_mem_read(tag_q)) begin
          state_d = S_RDELAY;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WDATA: begin
        // beat_q == 8 is the commit cycle: the full buffer goes to memory.
        if (beat_q == BEAT_DONE) begin
          mem_we  = 1'b1;
          state_d = S_IDLE;
          beat_d  = '0;
        end else if (bus.reqcyc) begin
          wbuf_d[beat_q[2:0]] = bus.req;
          beat_d              = beat_q + 4'd1;
        end
      end

      S_RDELAY: begin
        // Counts 0..LATENCY, i.e. LATENCY+1 cycles in this state.
        if (lat_q == LAT_LAST) begin
          state_d = S_RBURST;
          lat_d   = '0;
          beat_d  = '0;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end

      S_RBURST: begin
        if (bus.respack) begin
          if (beat_q == BEAT_LAST) begin
            state_d = S_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      tag_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      tag_q   <= tag_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
    end
  end

  // NOTE: the write buffer is storage, not control; it is not reset.
  // A reset mid-write never raises mem_we, so stale contents are harmless.
  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
  end

  sysbus_mem_array #(
    .WORDS (MEM_WORDS)
  ) u_array (
    .clk         (clk),
    .rd_idx      ({line_q, beat_q[2:0]}),
    .rd_data     (rd_data),
    .we          (mem_we),
    .wr_line_idx (line_q),
    .wr_line     (wbuf_q)
  );

  // Outputs decode straight from state, so reset clears them at once.
  assign bus.reqack  = (state_q == S_ACK);
  assign bus.respcyc = (state_q == S_RBURST);
  assign bus.resp    = bus.respcyc ? rd_data : '0;
  assign bus.resptag = bus.respcyc ? TAG_W'(tag_q) : '0;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Randomised scoreboard bench for sysbus_mem_responder.
// Tasks drive transactions and push expected read beats; a negedge monitor
// pops and compares every presented beat independently of the drivers.
module tb_sysbus_mem_responder;
  import sysbus_mem_responder_pkg::*;

  localparam int MEM_WORDS = 1024;
  localparam int LATENCY   = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sysbus_mem_responder_if bus();

  sysbus_mem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .LATENCY   (LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [12:0] tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model_mem [MEM_WORDS];

  int errors     = 0;
  int checks     = 0;
  int cyc        = 0;
  int ack_count  = 0;
  int first_rise = -1;
  int pop_count  = 0;
  int hold_cnt   = 0;
  int last_hold [8];
  bit prev_respcyc = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word index from the address rules: line number times 8 plus beat, wrapped.
  function automatic int word_idx(input logic [63:0] addr, input int beat);
    longint unsigned line;
    line = addr >> 6;
    return int'((line * 8 + longint'(beat)) % MEM_WORDS);
  endfunction

  function automatic logic [12:0] mk_tag(input sysbus_wr_e wr, input logic [3:0] typ,
                                         input logic [7:0] priv);
    sysbus_tag_t t;
    t.wr   = wr;
    t.typ  = typ;
    t.priv = priv;
    return 13'(t);
  endfunction

  // Monitor: scoreboard compare on every presented beat, zero checks otherwise.
  always @(negedge clk) begin
    if (bus.reqack) ack_count++;
    if (bus.respcyc) begin
      if (!prev_respcyc) first_rise = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_respcyc", 64'(bus.respcyc), 64'd0);
      end else begin
        check("resp_data", bus.resp, exp_q[0].data);
        check("resptag", 64'(bus.resptag), 64'(exp_q[0].tag));
        hold_cnt++;
        if (bus.respack) begin
          last_hold[pop_count % 8] = hold_cnt;
          hold_cnt = 0;
          void'(exp_q.pop_front());
          pop_count++;
        end
      end
    end else begin
      check("resp_idle_zero", bus.resp, 64'd0);
      check("resptag_idle_zero", 64'(bus.resptag), 64'd0);
    end
    prev_respcyc = bus.respcyc;
  end

  task automatic check_quiet_outputs();
    check("rst_reqack", 64'(bus.reqack), 64'd0);
    check("rst_respcyc", 64'(bus.respcyc), 64'd0);
    check("rst_resp", bus.resp, 64'd0);
    check("rst_resptag", 64'(bus.resptag), 64'd0);
  endtask

  // Present a request until reqack is seen; returns in the ACK cycle.
  task automatic issue(input logic [63:0] addr, input logic [12:0] tag, input bit keep,
                       output int ack_cyc);
    int n;
    n = 0;
    ack_cyc = -1;
    bus.reqcyc = 1'b1;
    bus.req    = addr;
    bus.reqtag = tag;
    while (n < 8) begin
      @(posedge clk); #1;
      n++;
      if (bus.reqack) begin
        ack_cyc = cyc;
        break;
      end
    end
    if (ack_cyc < 0) check("reqack_timeout", 64'(bus.reqack), 64'd1);
    if (!keep) bus.reqcyc = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [7:0][63:0] data,
                          input logic [7:0] gap_after, input bit continuous,
                          input logic [7:0] priv);
    int a0, ac;
    a0 = ack_count;
    issue(addr, mk_tag(WRITE, TYPE_MEMORY, priv), continuous, ac);
    @(posedge clk); #1;
    for (int b = 0; b < 8; b++) begin
      bus.reqcyc = 1'b1;
      bus.req    = data[b];
      @(posedge clk); #1;
      if (gap_after[b]) begin
        bus.reqcyc = 1'b0;
        bus.req    = {$urandom, $urandom};
        repeat (1 + $urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
    end
    bus.reqcyc = 1'b0;
    @(posedge clk); #1;
    for (int b = 0; b < 8; b++) model_mem[word_idx(addr, b)] = data[b];
    check("write_reqack_count", 64'(ack_count - a0), 64'd1);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [7:0] priv,
                         input int stall_beat, input int stall_len, input bit rand_ack,
                         input bit noise, input int abort_beat);
    logic [12:0] tag;
    exp_t        e;
    int          a0, ac, n, stall_left;
    bit          aborted;
    tag = mk_tag(READ, TYPE_MEMORY, priv);
    pop_count  = 0;
    hold_cnt   = 0;
    aborted    = 1'b0;
    first_rise = -1;
    for (int b = 0; b < 8; b++) begin
      e.data = model_mem[word_idx(addr, b)];
      e.tag  = tag;
      exp_q.push_back(e);
    end
    a0 = ack_count;
    bus.respack = 1'b1;
    issue(addr, tag, 1'b0, ac);
    stall_left = stall_len;
    n = 0;
    while (exp_q.size() != 0) begin
      if (n >= 300) begin
        check("read_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        break;
      end
      if (abort_beat >= 0 && bus.respcyc && pop_count == abort_beat) begin
        #2 reset = 1'b1;
        #1;
        check_quiet_outputs();
        exp_q.delete();
        hold_cnt = 0;
        @(posedge clk); #1;
        reset   = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (bus.respcyc && pop_count == stall_beat && stall_left > 0) begin
        bus.respack = 1'b0;
        stall_left--;
      end else begin
        bus.respack = rand_ack ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (noise && pop_count < 7) begin
        bus.reqcyc = 1'($urandom_range(0, 1));
        bus.req    = {$urandom, $urandom};
      end else begin
        bus.reqcyc = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.reqcyc  = 1'b0;
    bus.respack = 1'b0;
    if (!aborted) begin
      check("respcyc_drop", 64'(bus.respcyc), 64'd0);
      check("read_reqack_count", 64'(ack_count - a0), 64'd1);
      if (ac >= 0) check("read_latency", 64'(first_rise - ac), 64'(LATENCY + 2));
      if (stall_beat >= 0) check("stall_hold", 64'(last_hold[stall_beat]), 64'(stall_len + 1));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0][63:0] line;
    logic [63:0]      pool [6];
    int               ac, a0;

    bus.reqcyc  = 1'b0;
    bus.req     = '0;
    bus.reqtag  = '0;
    bus.respack = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_quiet_outputs();
    reset = 1'b0;
    @(posedge clk); #1;

    // Continuous write of line 0x1000 with 0x11..0x88.
    for (int b = 0; b < 8; b++) line[b] = 64'((b + 1) * 'h11);
    do_write(64'h1000, line, 8'h00, 1'b1, 8'h01);

    // Line 0x2000 written through an alias with high address bits set,
    // then an unaligned read at 0x2038.
    for (int b = 0; b < 8; b++) line[b] = {$urandom, $urandom};
    do_write(64'hABC0_0000_0000_2000, line, 8'h00, 1'b0, 8'h02);
    do_read(64'h2038, 8'hC3, -1, 0, 1'b0, 1'b0, -1);

    // Read back 0x1000, then again with a 3-cycle stall on beat 2.
    do_read(64'h1000, 8'h10, -1, 0, 1'b0, 1'b0, -1);
    do_read(64'h1000, 8'h11, 2, 3, 1'b0, 1'b0, -1);

    // Write with gaps after beats 1 and 5, read immediately after.
    for (int b = 0; b < 8; b++) line[b] = {$urandom, $urandom};
    do_write(64'h3000, line, 8'b0010_0010, 1'b0, 8'h33);
    do_read(64'h3000, 8'h34, -1, 0, 1'b0, 1'b0, -1);

    // Non-memory type: acknowledged, no response, memory untouched.
    a0 = ack_count;
    issue(64'h3000, mk_tag(READ, 4'b0010, 8'h55), 1'b0, ac);
    repeat (LATENCY + 12) begin
      @(posedge clk); #1;
    end
    a0 = ack_count - a0;
    issue(64'h3000, mk_tag(WRITE, 4'b0010, 8'h56), 1'b0, ac);
    repeat (LATENCY + 12) begin
      @(posedge clk); #1;
    end
    check("type2_reqack_count", 64'(a0), 64'd1);
    do_read(64'h3000, 8'h57, -1, 0, 1'b0, 1'b0, -1);

    // Reset during beat 4 of a read, then read the same line again.
    do_read(64'h1000, 8'h40, -1, 0, 1'b0, 1'b0, 4);
    do_read(64'h1000, 8'h41, -1, 0, 1'b0, 1'b0, -1);

    // Reset after three write beats: no memory update.
    issue(64'h1000, mk_tag(WRITE, TYPE_MEMORY, 8'h5A), 1'b0, ac);
    @(posedge clk); #1;
    for (int b = 0; b < 3; b++) begin
      bus.reqcyc = 1'b1;
      bus.req    = 64'hDEAD_0000 + 64'(b);
      @(posedge clk); #1;
    end
    bus.reqcyc = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_quiet_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_read(64'h1000, 8'h5B, -1, 0, 1'b0, 1'b0, -1);

    // Randomised mix over a small pool of lines.
    for (int i = 0; i < 6; i++) begin
      pool[i] = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) line[b] = {$urandom, $urandom};
      do_write(pool[i], line, 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    for (int t = 0; t < 24; t++) begin
      int k;
      k = $urandom_range(0, 5);
      if ($urandom_range(0, 2) == 0) begin
        for (int b = 0; b < 8; b++) line[b] = {$urandom, $urandom};
        do_write(pool[k], line, 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      end else begin
        do_read(pool[k], 8'($urandom), -1, 0, 1'b1, 1'b1, -1);
      end
    end

    repeat (4) begin
      @(posedge clk); #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
